shared_multi_channel_fifo: RTL and testbench

Single-clock FIFO holding 2**CH_WIDTH independent logical channels in one simple dual-port RAM, partitioned into equal per-channel regions of depth 2**ADDR_WIDTH.
Each channel has its own pointers, occupancy count, full/empty and almost-full/almost-empty flags.
One write port and one read port, each steered by a channel select.
Used for per-queue buffering in packet and DMA paths where a separate dual_clock_fifo per queue wastes block RAM.

---
 rtl/shared_multi_channel_fifo.sv | 179 +++++++++++++++++
 tb/tb_shared_multi_channel_fifo.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_multi_channel_fifo.sv
// shared_multi_channel_fifo: 2**CH_WIDTH logical FIFO channels that share one
// simple dual-port RAM. Each channel owns a fixed region of 2**ADDR_WIDTH words
// and keeps its own pointers, count and flags.
// Optional per-channel flush port: define SMCF_FLUSH_EN.
module shared_multi_channel_fifo #(
   parameter int DATA_WIDTH       = 8,
   parameter int CH_WIDTH         = 2,
   parameter int ADDR_WIDTH       = 4,
   parameter     OUTPUT_REG       = "FALSE",
   parameter int AFULL_THRESHOLD  = 2**ADDR_WIDTH-2,
   parameter int AEMPTY_THRESHOLD = 1
) (
   input  logic                                       i_clk,
   input  logic                                       i_arst,
`ifdef SMCF_FLUSH_EN
   input  logic [2**CH_WIDTH-1:0]                     i_flush,
`endif
   input  logic                                       i_we,
   input  logic [CH_WIDTH-1:0]                        i_wch,
   input  logic [DATA_WIDTH-1:0]                      i_wdata,
   input  logic                                       i_re,
   input  logic [CH_WIDTH-1:0]                        i_rch,
   output logic                                       o_rvalid,
   output logic [DATA_WIDTH-1:0]                      o_rdata,
   output logic [CH_WIDTH-1:0]                        o_rch,
   output logic [2**CH_WIDTH-1:0]                     o_full,
   output logic [2**CH_WIDTH-1:0]                     o_empty,
   output logic [2**CH_WIDTH-1:0]                     o_afull,
   output logic [2**CH_WIDTH-1:0]                     o_aempty,
   output logic [(2**CH_WIDTH)*(ADDR_WIDTH+1)-1:0]    o_cnt,
   output logic                                       o_werr,
   output logic                                       o_rerr
);

   localparam int NCH  = 2**CH_WIDTH;
   localparam int CNTW = ADDR_WIDTH+1;
   localparam logic [CNTW-1:0] LP_DEPTH = CNTW'(2**ADDR_WIDTH);
   localparam logic [CNTW-1:0] LP_AFULL = CNTW'(AFULL_THRESHOLD);
   localparam logic [CNTW-1:0] LP_AEMPTY = CNTW'(AEMPTY_THRESHOLD);

   logic [DATA_WIDTH-1:0]          r_mem [NCH*(2**ADDR_WIDTH)];
   logic [ADDR_WIDTH-1:0]          r_wptr [NCH];
   logic [ADDR_WIDTH-1:0]          r_rptr [NCH];
   logic [CNTW-1:0]                r_cnt  [NCH];

   logic [NCH-1:0]                 w_flush;
   logic [NCH-1:0]                 w_winc;
   logic [NCH-1:0]                 w_rinc;
   logic                           w_wacc;
   logic                           w_racc;
   logic [CH_WIDTH+ADDR_WIDTH-1:0] w_waddr;
   logic [CH_WIDTH+ADDR_WIDTH-1:0] w_raddr;

   logic                           r_s1_valid;
   logic [DATA_WIDTH-1:0]          r_s1_data;
   logic [CH_WIDTH-1:0]            r_s1_ch;
   logic                           r_werr;
   logic                           r_rerr;

`ifdef SMCF_FLUSH_EN
   assign w_flush = i_flush;
`else
   assign w_flush = '0;
`endif

   // Flags and packed counts decoded from the registered per-channel counts
   always_comb begin
      o_cnt = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         o_full[c]   = (r_cnt[c] == LP_DEPTH);
         o_empty[c]  = (r_cnt[c] == '0);
         o_afull[c]  = (r_cnt[c] >= LP_AFULL);
         o_aempty[c] = (r_cnt[c] <= LP_AEMPTY);
         o_cnt[c*CNTW +: CNTW] = r_cnt[c];
      end
   end

   // Accept decisions; a flush on the addressed channel silently drops the op
   assign w_wacc  = i_we & ~o_full[i_wch]  & ~w_flush[i_wch];
   assign w_racc  = i_re & ~o_empty[i_rch] & ~w_flush[i_rch];
   assign w_waddr = {i_wch, r_wptr[i_wch]};
   assign w_raddr = {i_rch, r_rptr[i_rch]};

   // Per-channel one-hot increment/decrement requests
   always_comb begin
      w_winc = '0;
      w_rinc = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         w_winc[c] = w_wacc && (i_wch == CH_WIDTH'(c));
         w_rinc[c] = w_racc && (i_rch == CH_WIDTH'(c));
      end
   end

   // Shared storage write port
   always_ff @(posedge i_clk) begin
      if (w_wacc) r_mem[w_waddr] <= i_wdata;
   end

   // Per-channel pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_cnt[c]  <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (w_flush[c]) begin
               r_wptr[c] <= '0;
               r_rptr[c] <= '0;
               r_cnt[c]  <= '0;
            end else begin
               if (w_winc[c]) r_wptr[c] <= r_wptr[c] + ADDR_WIDTH'(1);
               if (w_rinc[c]) r_rptr[c] <= r_rptr[c] + ADDR_WIDTH'(1);
               unique case ({w_winc[c], w_rinc[c]})
                  2'b10:   r_cnt[c] <= r_cnt[c] + CNTW'(1);
                  2'b01:   r_cnt[c] <= r_cnt[c] - CNTW'(1);
                  default: r_cnt[c] <= r_cnt[c];
               endcase
            end
         end
      end
   end

   // First read stage plus registered reject pulses
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_ch    <= '0;
         r_werr     <= 1'b0;
         r_rerr     <= 1'b0;
      end else begin
         r_s1_valid <= w_racc;
         if (w_racc) begin
            r_s1_data <= r_mem[w_raddr];
            r_s1_ch   <= i_rch;
         end
         r_werr <= i_we & o_full[i_wch]  & ~w_flush[i_wch];
         r_rerr <= i_re & o_empty[i_rch] & ~w_flush[i_rch];
      end
   end

   assign o_werr = r_werr;
   assign o_rerr = r_rerr;

   generate
      if (OUTPUT_REG == "TRUE") begin : g_oreg
         logic                  r_s2_valid;
         logic [DATA_WIDTH-1:0] r_s2_data;
         logic [CH_WIDTH-1:0]   r_s2_ch;

         // Optional output register stage (read latency 2)
         always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
               r_s2_ch    <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
                  r_s2_ch   <= r_s1_ch;
               end
            end
         end

         assign o_rvalid = r_s2_valid;
         assign o_rdata  = r_s2_data;
         assign o_rch    = r_s2_ch;
      end else begin : g_noreg
         assign o_rvalid = r_s1_valid;
         assign o_rdata  = r_s1_data;
         assign o_rch    = r_s1_ch;
      end
   endgenerate

endmodule

// File: tb/tb_shared_multi_channel_fifo.sv
// Directed bench for shared_multi_channel_fifo (defaults, plus one instance
// with the output register enabled). Flush steps run when SMCF_FLUSH_EN is set.
`timescale 1ns/1ps
module tb_shared_multi_channel_fifo;

   logic        i_clk = 1'b0;
   logic        i_arst;
   logic        we, re;
   logic [1:0]  wch, rch;
   logic [7:0]  wdata;
   logic        rvalid, werr, rerr;
   logic [7:0]  rdata;
   logic [1:0]  rchout;
   logic [3:0]  full, empty, afull, aempty;
   logic [19:0] cnt;
`ifdef SMCF_FLUSH_EN
   logic [3:0]  flush;
`endif

   logic        we2, re2;
   logic [1:0]  wch2, rch2;
   logic [7:0]  wdata2;
   logic        rvalid2, werr2, rerr2;
   logic [7:0]  rdata2;
   logic [1:0]  rchout2;
   logic [3:0]  full2, empty2, afull2, aempty2;
   logic [19:0] cnt2;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] sb[$];
   logic [7:0] e;

   always #5 i_clk = ~i_clk;

   shared_multi_channel_fifo u_dut (
      .i_clk(i_clk), .i_arst(i_arst),
`ifdef SMCF_FLUSH_EN
      .i_flush(flush),
`endif
      .i_we(we), .i_wch(wch), .i_wdata(wdata),
      .i_re(re), .i_rch(rch),
      .o_rvalid(rvalid), .o_rdata(rdata), .o_rch(rchout),
      .o_full(full), .o_empty(empty), .o_afull(afull), .o_aempty(aempty),
      .o_cnt(cnt), .o_werr(werr), .o_rerr(rerr)
   );

   shared_multi_channel_fifo #(.OUTPUT_REG("TRUE")) u_dut2 (
      .i_clk(i_clk), .i_arst(i_arst),
`ifdef SMCF_FLUSH_EN
      .i_flush(4'b0000),
`endif
      .i_we(we2), .i_wch(wch2), .i_wdata(wdata2),
      .i_re(re2), .i_rch(rch2),
      .o_rvalid(rvalid2), .o_rdata(rdata2), .o_rch(rchout2),
      .o_full(full2), .o_empty(empty2), .o_afull(afull2), .o_aempty(aempty2),
      .o_cnt(cnt2), .o_werr(werr2), .o_rerr(rerr2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] cnt_of(input logic [19:0] v, input int ch);
      return v[ch*5 +: 5];
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; re = 1'b0;
   endtask

   initial begin
      i_arst = 1'b1;
      we = 0; re = 0; wch = 0; rch = 0; wdata = 0;
      we2 = 0; re2 = 0; wch2 = 0; rch2 = 0; wdata2 = 0;
`ifdef SMCF_FLUSH_EN
      flush = '0;
`endif
      step(); step();
      i_arst = 1'b0;
      step();

      // reset state
      chk("rst_empty", empty, 4'hF);
      chk("rst_full", full, 4'h0);
      chk("rst_aempty", aempty, 4'hF);
      chk("rst_afull", afull, 4'h0);
      chk("rst_cnt", cnt, 20'h0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_rch", rchout, 2'd0);
      chk("rst_errs", {werr, rerr}, 2'b00);

      // 1: write ch1 then read it, L=1
      we = 1; wch = 1; wdata = 8'hA5;
      step();
      idle();
      chk("t1_empty1_low", empty[1], 1'b0);
      chk("t1_cnt1", cnt_of(cnt, 1), 5'd1);
      re = 1; rch = 1;
      step();
      idle();
      chk("t1_rvalid", rvalid, 1'b1);
      chk("t1_rdata", rdata, 8'hA5);
      chk("t1_rch", rchout, 2'd1);
      chk("t1_empty1_high", empty[1], 1'b1);
      step();
      chk("t1_rvalid_pulse", rvalid, 1'b0);

      // 2: fill ch2, threshold flags, overflow attempt
      for (int i = 0; i < 16; i++) begin
         we = 1; wch = 2; wdata = 8'(i);
         step();
         if (i == 0)  chk("t2_aempty_at1", aempty[2], 1'b1);
         if (i == 1)  chk("t2_aempty_at2", aempty[2], 1'b0);
         if (i == 12) chk("t2_afull_at13", afull[2], 1'b0);
         if (i == 13) chk("t2_afull_at14", afull[2], 1'b1);
         if (i == 14) chk("t2_full_at15", full[2], 1'b0);
      end
      chk("t2_full", full, 4'b0100);
      chk("t2_cnt2", cnt_of(cnt, 2), 5'd16);
      wdata = 8'hFF;
      step();
      idle();
      chk("t2_werr", werr, 1'b1);
      chk("t2_cnt2_hold", cnt_of(cnt, 2), 5'd16);
      chk("t2_empty_others", empty, 4'b1011);
      chk("t2_afull_others", afull, 4'b0100);
      step();
      chk("t2_werr_pulse", werr, 1'b0);

      // 3: interleaved channels keep independent order
      we = 1;
      wch = 0; wdata = 8'h10; step();
      wch = 3; wdata = 8'h30; step();
      wch = 0; wdata = 8'h11; step();
      wch = 3; wdata = 8'h31; step();
      wch = 0; wdata = 8'h12; step();
      we = 0;
      chk("t3_cnt0", cnt_of(cnt, 0), 5'd3);
      chk("t3_cnt3", cnt_of(cnt, 3), 5'd2);
      re = 1;
      rch = 3; step(); chk("t3_r0", {rvalid, rchout, rdata}, {1'b1, 2'd3, 8'h30});
      rch = 0; step(); chk("t3_r1", {rvalid, rchout, rdata}, {1'b1, 2'd0, 8'h10});
      rch = 3; step(); chk("t3_r2", {rvalid, rchout, rdata}, {1'b1, 2'd3, 8'h31});
      rch = 0; step(); chk("t3_r3", {rvalid, rchout, rdata}, {1'b1, 2'd0, 8'h11});
      rch = 0; step(); chk("t3_r4", {rvalid, rchout, rdata}, {1'b1, 2'd0, 8'h12});
      re = 0;
      step();
      chk("t3_idle", rvalid, 1'b0);

      // 4: read of empty ch0, then same-cycle write+read on empty ch0
      re = 1; rch = 0;
      step();
      idle();
      chk("t4_rerr", rerr, 1'b1);
      chk("t4_no_rvalid", rvalid, 1'b0);
      chk("t4_cnt0", cnt_of(cnt, 0), 5'd0);
      step();
      chk("t4_rerr_pulse", rerr, 1'b0);
      we = 1; wch = 0; wdata = 8'h77; re = 1; rch = 0;
      step();
      idle();
      chk("t4_wr_rerr", rerr, 1'b1);
      chk("t4_wr_no_rvalid", rvalid, 1'b0);
      chk("t4_wr_cnt0", cnt_of(cnt, 0), 5'd1);
      re = 1; rch = 0;
      step();
      idle();
      chk("t4_readback", {rvalid, rdata}, {1'b1, 8'h77});

      // 5: full ch1 with simultaneous write+read, then drain
      for (int i = 0; i < 16; i++) begin
         we = 1; wch = 1; wdata = 8'(8'hB0 + i);
         step();
      end
      chk("t5_full1", full[1], 1'b1);
      we = 1; wch = 1; wdata = 8'hEE; re = 1; rch = 1;
      step();
      idle();
      chk("t5_oldest", {rvalid, rdata}, {1'b1, 8'hB0});
      chk("t5_werr", werr, 1'b1);
      chk("t5_cnt1", cnt_of(cnt, 1), 5'd15);
      for (int i = 1; i < 16; i++) begin
         re = 1; rch = 1;
         step();
         chk("t5_drain", {rvalid, rdata}, {1'b1, 8'(8'hB0 + i)});
      end
      re = 0;
      chk("t5_empty1", empty[1], 1'b1);

      // 5b: wraparound through ch1 at low occupancy
      sb.delete();
      for (int i = 0; i < 40; i++) begin
         we = 1; wch = 1; wdata = 8'(i * 7 + 3);
         re = (i >= 2); rch = 1;
         step();
         sb.push_back(8'(i * 7 + 3));
         if (i >= 2) begin
            e = sb.pop_front();
            chk("t5_wrap", {rvalid, rdata}, {1'b1, e});
            chk("t5_wrap_cnt", cnt_of(cnt, 1), 5'd2);
         end
      end
      we = 0;
      for (int i = 0; i < 2; i++) begin
         re = 1; rch = 1;
         step();
         e = sb.pop_front();
         chk("t5_wrap_tail", {rvalid, rdata}, {1'b1, e});
      end
      re = 0;
      step();
      chk("t5_wrap_empty", empty[1], 1'b1);

      // 5c: output register instance, latency 2, back-to-back
      we2 = 1; wch2 = 2; wdata2 = 8'h5A; step();
      wdata2 = 8'h5B; step();
      we2 = 0; re2 = 1; rch2 = 2;
      step();
      chk("t5c_lat1", rvalid2, 1'b0);
      step();
      re2 = 0;
      chk("t5c_lat2", {rvalid2, rchout2, rdata2}, {1'b1, 2'd2, 8'h5A});
      step();
      chk("t5c_b2b", {rvalid2, rchout2, rdata2}, {1'b1, 2'd2, 8'h5B});
      step();
      chk("t5c_done", rvalid2, 1'b0);

`ifdef SMCF_FLUSH_EN
      // 6: flush ch3 at cnt 5 together with a write
      for (int i = 0; i < 5; i++) begin
         we = 1; wch = 3; wdata = 8'(8'h60 + i);
         step();
      end
      chk("t6_cnt3", cnt_of(cnt, 3), 5'd5);
      flush = 4'b1000; we = 1; wch = 3; wdata = 8'h99;
      step();
      flush = '0; we = 0;
      chk("t6_cnt3_zero", cnt_of(cnt, 3), 5'd0);
      chk("t6_empty3", empty[3], 1'b1);
      chk("t6_no_werr", werr, 1'b0);
      we = 1; wch = 3; wdata = 8'h42;
      step();
      we = 0; re = 1; rch = 3;
      step();
      re = 0;
      chk("t6_newdata", {rvalid, rchout, rdata}, {1'b1, 2'd3, 8'h42});
`endif

      // reset mid-flight drops a pending read result
      we = 1; wch = 0; wdata = 8'h21; step();
      we = 0; re = 1; rch = 0;
      @(posedge i_clk);
      re = 0;
      #2 i_arst = 1'b1;
      #1;
      chk("rst_mid_rvalid", rvalid, 1'b0);
      chk("rst_mid_cnt", cnt, 20'h0);
      step();
      i_arst = 1'b0;
      step();
      chk("rst_after_rvalid", rvalid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
